crcu_rst_ctl_apb_regs: RTL and testbench

CRCU_RST_CTL_APB_REGS -- requirements
Module: crcu_rst_ctl_apb_regs

---
 rtl/crcu_pkg.sv | 48 ++++
 rtl/crcu_apb_wait_gen.sv | 41 ++++
 rtl/crcu_rst_ctl_apb_regs.sv | 181 ++++++++++++++++++
 tb/tb_crcu_rst_ctl_apb_regs.sv | 232 +++++++++++++++++++++++
 4 files changed

// File: rtl/crcu_pkg.sv
// Shared definitions for the CRCU reset-control APB register block.
`timescale 1ns/1ps
package crcu_pkg;

   localparam int unsigned DATA_W          = 32;
   localparam int unsigned CTL_W           = 3;
   localparam int unsigned CTL_EN_BIT      = 0;
   localparam int unsigned CTL_ASYNC_BIT   = 1;
   localparam int unsigned CTL_POSEDGE_BIT = 2;
   localparam int unsigned CTL_STRIDE      = 4;
   localparam int unsigned LOCK_OFFSET     = 32'h20;
   localparam int unsigned ERR_CNT_OFFSET  = 32'h24;
   localparam int unsigned ERR_CNT_W       = 8;
   localparam int unsigned WAIT_CNT_W      = 4;

   localparam logic [DATA_W-1:0]    LOCK_KEY    = 32'h5A5A_C0DE;
   localparam logic [ERR_CNT_W-1:0] ERR_CNT_MAX = 8'hFF;

   typedef enum logic [0:0] {
      ST_IDLE   = 1'b0,
      ST_ACCESS = 1'b1
   } apb_state_e;

   // Per-unit reset control payload
   typedef struct packed {
      logic posedge_sel;  // 1: posedge release, 0: negedge
      logic async_sel;    // 1: async assert, 0: sync
      logic enable;
   } rst_ctl_t;

   function automatic rst_ctl_t ctl_from_bits(input logic [CTL_W-1:0] b);
      rst_ctl_t c;
      c.enable      = b[CTL_EN_BIT];
      c.async_sel   = b[CTL_ASYNC_BIT];
      c.posedge_sel = b[CTL_POSEDGE_BIT];
      return c;
   endfunction

   function automatic logic [DATA_W-1:0] ctl_to_word(input rst_ctl_t c);
      logic [DATA_W-1:0] w;
      w                  = '0;
      w[CTL_EN_BIT]      = c.enable;
      w[CTL_ASYNC_BIT]   = c.async_sel;
      w[CTL_POSEDGE_BIT] = c.posedge_sel;
      return w;
   endfunction

endpackage

// File: rtl/crcu_apb_wait_gen.sv
// Wait-state counter and PREADY generation for the APB access phase.
`timescale 1ns/1ps
module crcu_apb_wait_gen
   import crcu_pkg::*;
#(
   parameter int unsigned WAIT_STATES = 1
) (
   input  logic clk,
   input  logic rst,
   input  logic in_access,
   input  logic xfer_active,
   output logic pready_c
);

   logic [WAIT_CNT_W-1:0] wait_cnt_q;
   logic [WAIT_CNT_W-1:0] wait_cnt_d;

   // Ready once the programmed number of wait cycles has elapsed
   always_comb begin
      pready_c = in_access && xfer_active &&
                 (wait_cnt_q == WAIT_CNT_W'(WAIT_STATES));
   end

   // Count while waiting; any idle, drop or completion clears the count
   always_comb begin
      wait_cnt_d = '0;
      if (in_access && xfer_active && !pready_c) begin
         wait_cnt_d = wait_cnt_q + WAIT_CNT_W'(1);
      end
   end

   // Counter register
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         wait_cnt_q <= '0;
      end else begin
         wait_cnt_q <= wait_cnt_d;
      end
   end

endmodule

// File: rtl/crcu_rst_ctl_apb_regs.sv
// APB3 register block holding per-unit reset-control words behind a one-shot lock.
`timescale 1ns/1ps
module crcu_rst_ctl_apb_regs
   import crcu_pkg::*;
#(
   parameter int unsigned NUM_REGS    = 4,
   parameter int unsigned WAIT_STATES = 1,
   parameter int unsigned ADDR_W      = 8
) (
   input  logic                       CRCU_CLK,
   input  logic                       CRCU_RST,
   input  logic                       PSEL,
   input  logic                       PENABLE,
   input  logic                       PWRITE,
   input  logic [ADDR_W-1:0]          PADDR,
   input  logic [DATA_W-1:0]          PWDATA,
   output logic [DATA_W-1:0]          PRDATA,
   output logic                       PREADY,
   output logic                       PSLVERR,
   output logic [NUM_REGS*DATA_W-1:0] rst_ctl_reg,
   output logic [NUM_REGS-1:0]        reg_update
);

   apb_state_e state_q;
   apb_state_e state_d;

   rst_ctl_t              ctl_q [NUM_REGS];
   rst_ctl_t              ctl_d [NUM_REGS];
   logic                  locked_q;
   logic                  locked_d;
   logic [ERR_CNT_W-1:0]  err_cnt_q;
   logic [ERR_CNT_W-1:0]  err_cnt_d;
   logic [NUM_REGS-1:0]   reg_update_q;
   logic [NUM_REGS-1:0]   reg_update_d;

   logic                  xfer_active;
   logic                  pready_c;
   logic [NUM_REGS-1:0]   ctl_sel;
   logic                  lock_hit;
   logic                  err_cnt_hit;
   logic                  addr_err;
   logic [DATA_W-1:0]     rdata_c;
   logic                  wr_commit;
   logic                  resp_err;

   assign xfer_active = PSEL && PENABLE;

   crcu_apb_wait_gen #(
      .WAIT_STATES (WAIT_STATES)
   ) u_wait_gen (
      .clk         (CRCU_CLK),
      .rst         (CRCU_RST),
      .in_access   (state_q == ST_ACCESS),
      .xfer_active (xfer_active),
      .pready_c    (pready_c)
   );

   // Address decode, error classification and read-data mux
   always_comb begin
      ctl_sel     = '0;
      rdata_c     = '0;
      lock_hit    = (PADDR == ADDR_W'(LOCK_OFFSET));
      err_cnt_hit = (PADDR == ADDR_W'(ERR_CNT_OFFSET));
      for (int unsigned i = 0; i < NUM_REGS; i++) begin
         if (PADDR == ADDR_W'(CTL_STRIDE * i)) begin
            ctl_sel[i] = 1'b1;
            rdata_c    = ctl_to_word(ctl_q[i]);
         end
      end
      if (lock_hit) begin
         rdata_c = {{(DATA_W-1){1'b0}}, locked_q};
      end
      if (err_cnt_hit) begin
         rdata_c = DATA_W'(err_cnt_q);
      end
      addr_err = (PADDR[1:0] != 2'b00) ||
                 !((|ctl_sel) || lock_hit || err_cnt_hit) ||
                 (PWRITE && (|ctl_sel) && locked_q);
   end

   // FSM state register
   always_ff @(posedge CRCU_CLK or posedge CRCU_RST) begin
      if (CRCU_RST) begin
         state_q <= ST_IDLE;
      end else begin
         state_q <= state_d;
      end
   end

   // FSM next state: a dropped select or a completed beat returns to IDLE
   always_comb begin
      state_d = state_q;
      case (state_q)
         ST_IDLE: begin
            if (xfer_active) begin
               state_d = ST_ACCESS;
            end
         end
         ST_ACCESS: begin
            if (!xfer_active || pready_c) begin
               state_d = ST_IDLE;
            end
         end
         default: state_d = ST_IDLE;
      endcase
   end

   // FSM outputs: APB response and commit qualifiers, all tied to the ready beat
   always_comb begin
      PREADY    = 1'b0;
      PSLVERR   = 1'b0;
      PRDATA    = '0;
      wr_commit = 1'b0;
      resp_err  = 1'b0;
      if (state_q == ST_ACCESS && pready_c) begin
         PREADY    = 1'b1;
         resp_err  = addr_err;
         PSLVERR   = addr_err;
         wr_commit = PWRITE && !addr_err;
         if (!PWRITE && !addr_err) begin
            PRDATA = rdata_c;
         end
      end
   end

   // Register updates: ctl writes re-lock, error counter saturates, clear wins
   always_comb begin
      ctl_d        = ctl_q;
      locked_d     = locked_q;
      err_cnt_d    = err_cnt_q;
      reg_update_d = '0;
      if (wr_commit) begin
         for (int unsigned i = 0; i < NUM_REGS; i++) begin
            if (ctl_sel[i]) begin
               ctl_d[i]        = ctl_from_bits(PWDATA[CTL_W-1:0]);
               reg_update_d[i] = 1'b1;
               locked_d        = 1'b1;
            end
         end
         if (lock_hit) begin
            locked_d = (PWDATA != LOCK_KEY);
         end
      end
      if (resp_err && err_cnt_q != ERR_CNT_MAX) begin
         err_cnt_d = err_cnt_q + ERR_CNT_W'(1);
      end
      if (wr_commit && err_cnt_hit) begin
         err_cnt_d = '0;
      end
   end

   // Register state
   always_ff @(posedge CRCU_CLK or posedge CRCU_RST) begin
      if (CRCU_RST) begin
         for (int unsigned i = 0; i < NUM_REGS; i++) begin
            ctl_q[i] <= '0;
         end
         locked_q     <= 1'b1;
         err_cnt_q    <= '0;
         reg_update_q <= '0;
      end else begin
         for (int unsigned i = 0; i < NUM_REGS; i++) begin
            ctl_q[i] <= ctl_d[i];
         end
         locked_q     <= locked_d;
         err_cnt_q    <= err_cnt_d;
         reg_update_q <= reg_update_d;
      end
   end

   // Expose ctl registers as 32-bit words
   always_comb begin
      rst_ctl_reg = '0;
      for (int unsigned i = 0; i < NUM_REGS; i++) begin
         rst_ctl_reg[DATA_W*i +: DATA_W] = ctl_to_word(ctl_q[i]);
      end
   end

   assign reg_update = reg_update_q;

endmodule

// File: tb/tb_crcu_rst_ctl_apb_regs.sv
// Scoreboard bench for crcu_rst_ctl_apb_regs: APB driver queues expected responses, monitor checks them.
`timescale 1ns/1ps
module tb_crcu_rst_ctl_apb_regs;

   localparam int unsigned NR = 4;
   localparam int unsigned AW = 8;
   localparam logic [31:0] KEY = 32'h5A5A_C0DE;

   logic            CRCU_CLK;
   logic            CRCU_RST;
   logic            PSEL;
   logic            PENABLE;
   logic            PWRITE;
   logic [AW-1:0]   PADDR;
   logic [31:0]     PWDATA;
   logic [31:0]     PRDATA;
   logic            PREADY;
   logic            PSLVERR;
   logic [NR*32-1:0] rst_ctl_reg;
   logic [NR-1:0]   reg_update;

   typedef struct {
      logic [31:0] rdata;
      logic        slverr;
      logic        chk_rdata;
      logic [7:0]  addr;
   } exp_t;

   exp_t exp_q[$];
   int   vectors;
   int   miscompares;

   crcu_rst_ctl_apb_regs #(
      .NUM_REGS    (NR),
      .WAIT_STATES (1),
      .ADDR_W      (AW)
   ) dut (
      .CRCU_CLK    (CRCU_CLK),
      .CRCU_RST    (CRCU_RST),
      .PSEL        (PSEL),
      .PENABLE     (PENABLE),
      .PWRITE      (PWRITE),
      .PADDR       (PADDR),
      .PWDATA      (PWDATA),
      .PRDATA      (PRDATA),
      .PREADY      (PREADY),
      .PSLVERR     (PSLVERR),
      .rst_ctl_reg (rst_ctl_reg),
      .reg_update  (reg_update)
   );

   initial CRCU_CLK = 1'b0;
   always #5 CRCU_CLK = ~CRCU_CLK;

   // Monitor: every ready beat pops one expectation
   always @(negedge CRCU_CLK) begin
      if (PSEL && PENABLE && PREADY) begin
         if (exp_q.size() == 0) begin
            vectors++;
            miscompares++;
            $display("FAIL apb_resp unexpected beat addr=%h pslverr=%b prdata=%h", PADDR, PSLVERR, PRDATA);
         end else begin
            exp_t e;
            e = exp_q.pop_front();
            vectors++;
            if (PSLVERR !== e.slverr || (e.chk_rdata && PRDATA !== e.rdata)) begin
               miscompares++;
               $display("FAIL apb_resp addr=%h got pslverr=%b prdata=%h want pslverr=%b prdata=%h",
                        e.addr, PSLVERR, PRDATA, e.slverr, e.rdata);
            end
         end
      end
   end

   task automatic check_val(input string name, input logic [NR*32-1:0] act, input logic [NR*32-1:0] exp);
      vectors++;
      if (act !== exp) begin
         miscompares++;
         $display("FAIL %s got %h want %h", name, act, exp);
      end
   endtask

   task automatic apb_xfer(input logic wr, input logic [7:0] addr, input logic [31:0] wdata,
                           input logic [31:0] exp_rdata, input logic exp_err);
      exp_t e;
      bit   done;
      e.rdata     = exp_rdata;
      e.slverr    = exp_err;
      e.chk_rdata = !wr && !exp_err;
      e.addr      = addr;
      exp_q.push_back(e);
      @(posedge CRCU_CLK); #1;
      PSEL = 1'b1; PENABLE = 1'b0; PWRITE = wr; PADDR = addr; PWDATA = wdata;
      @(posedge CRCU_CLK); #1;
      PENABLE = 1'b1;
      done = 1'b0;
      for (int c = 0; c < 40 && !done; c++) begin
         @(negedge CRCU_CLK);
         if (PREADY) done = 1'b1;
      end
      if (!done) begin
         vectors++;
         miscompares++;
         $display("FAIL pready_timeout addr=%h got PREADY=0 want 1", addr);
         if (exp_q.size() != 0) void'(exp_q.pop_front());
      end
      @(posedge CRCU_CLK); #1;
      PSEL = 1'b0; PENABLE = 1'b0;
   endtask

   task automatic rd(input logic [7:0] addr, input logic [31:0] exp_rdata, input logic exp_err);
      apb_xfer(1'b0, addr, 32'h0, exp_rdata, exp_err);
   endtask

   task automatic wr(input logic [7:0] addr, input logic [31:0] wdata, input logic exp_err);
      apb_xfer(1'b1, addr, wdata, 32'h0, exp_err);
   endtask

   // Begin a write and return while the FSM sits in ACCESS with PREADY still low
   task automatic start_write_hold(input logic [7:0] addr, input logic [31:0] wdata);
      @(posedge CRCU_CLK); #1;
      PSEL = 1'b1; PENABLE = 1'b0; PWRITE = 1'b1; PADDR = addr; PWDATA = wdata;
      @(posedge CRCU_CLK); #1;
      PENABLE = 1'b1;
      @(posedge CRCU_CLK); #1;
   endtask

   initial begin
      #1_000_000;
      $display("FAIL watchdog got timeout want completion");
      $fatal(1, "watchdog");
   end

   initial begin
      vectors = 0; miscompares = 0;
      CRCU_RST = 1'b1; PSEL = 1'b0; PENABLE = 1'b0; PWRITE = 1'b0; PADDR = '0; PWDATA = '0;
      repeat (3) @(posedge CRCU_CLK);
      #1;
      check_val("reset_rst_ctl_reg", rst_ctl_reg, '0);
      check_val("reset_outputs", {PREADY, PSLVERR, PRDATA, reg_update}, '0);
      CRCU_RST = 1'b0;

      // Basic reads after reset
      rd(8'h00, 32'h0, 1'b0);
      rd(8'h20, 32'h1, 1'b0);
      rd(8'h24, 32'h0, 1'b0);

      // Unlock then write ctl1 with all ones; only bits [2:0] land
      wr(8'h20, KEY, 1'b0);
      rd(8'h20, 32'h0, 1'b0);
      wr(8'h04, 32'hFFFF_FFFF, 1'b0);
      check_val("ctl1_after_write", rst_ctl_reg, {32'h0, 32'h0, 32'h7, 32'h0});
      check_val("reg_update_pulse", NR*32'(reg_update), NR*32'(4'b0010));
      @(posedge CRCU_CLK); #1;
      check_val("reg_update_clear", NR*32'(reg_update), '0);
      rd(8'h20, 32'h1, 1'b0);
      rd(8'h04, 32'h7, 1'b0);

      // Locked ctl write errors and changes nothing
      wr(8'h00, 32'h5, 1'b1);
      check_val("ctl_after_locked_wr", rst_ctl_reg, {32'h0, 32'h0, 32'h7, 32'h0});
      rd(8'h00, 32'h0, 1'b0);
      rd(8'h24, 32'h1, 1'b0);

      // Unmapped and misaligned reads, then clear
      wr(8'h24, 32'h0, 1'b0);
      rd(8'h30, 32'h0, 1'b1);
      rd(8'h02, 32'h0, 1'b1);
      rd(8'h24, 32'h2, 1'b0);
      wr(8'h24, 32'hDEAD_BEEF, 1'b0);
      rd(8'h24, 32'h0, 1'b0);

      // Wrong key keeps the block locked
      wr(8'h20, 32'h1234_5678, 1'b0);
      rd(8'h20, 32'h1, 1'b0);

      // Last ctl register and unmapped slot just past it
      wr(8'h20, KEY, 1'b0);
      wr(8'h0C, 32'h0000_0006, 1'b0);
      check_val("ctl3_after_write", rst_ctl_reg, {32'h6, 32'h0, 32'h7, 32'h0});
      check_val("reg_update_ctl3", NR*32'(reg_update), NR*32'(4'b1000));
      wr(8'h10, 32'h1, 1'b1);
      rd(8'h0C, 32'h6, 1'b0);
      rd(8'h24, 32'h1, 1'b0);

      // Dropped select mid-wait: no commit, lock untouched
      wr(8'h20, KEY, 1'b0);
      start_write_hold(8'h00, 32'h1);
      check_val("pready_mid_wait", NR*32'(PREADY), '0);
      PSEL = 1'b0; PENABLE = 1'b0;
      repeat (2) @(posedge CRCU_CLK);
      #1;
      check_val("ctl_after_drop", rst_ctl_reg, {32'h6, 32'h0, 32'h7, 32'h0});
      rd(8'h20, 32'h0, 1'b0);
      rd(8'h00, 32'h0, 1'b0);
      rd(8'h24, 32'h1, 1'b0);

      // Reset during an access aborts it
      start_write_hold(8'h00, 32'h1);
      CRCU_RST = 1'b1;
      #1;
      check_val("rst_mid_access_regs", rst_ctl_reg, '0);
      check_val("rst_mid_access_outs", {PREADY, PSLVERR, PRDATA, reg_update}, '0);
      PSEL = 1'b0; PENABLE = 1'b0;
      repeat (2) @(posedge CRCU_CLK);
      #1;
      CRCU_RST = 1'b0;
      check_val("after_rst_regs", rst_ctl_reg, '0);
      rd(8'h20, 32'h1, 1'b0);
      rd(8'h00, 32'h0, 1'b0);
      rd(8'h0C, 32'h0, 1'b0);
      rd(8'h24, 32'h0, 1'b0);

      // Error counter saturation
      for (int n = 0; n < 300; n++) begin
         rd(8'h30, 32'h0, 1'b1);
      end
      rd(8'h24, 32'hFF, 1'b0);
      wr(8'h24, 32'h0, 1'b0);
      rd(8'h24, 32'h0, 1'b0);

      repeat (3) @(posedge CRCU_CLK);
      if (exp_q.size() != 0) begin
         vectors++;
         miscompares++;
         $display("FAIL scoreboard_drain got %0d pending want 0", exp_q.size());
      end
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
